mux8x1_8bit: RTL and testbench
==============================

MUX8X1_8BIT -- requirements
Module: mux8x1_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each input and of the output.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port: Clock  input  1  rising-edge clock for the output register.
REQ-004 Port: Reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: I0  input  WIDTH  data input 0.
REQ-006 Port: I1  input  WIDTH  data input 1.
REQ-007 Port: I2  input  WIDTH  data input 2.
REQ-008 Port: I3  input  WIDTH  data input 3.
REQ-009 Port: I4  input  WIDTH  data input 4.
REQ-010 Port: I5  input  WIDTH  data input 5.
REQ-011 Port: I6  input  WIDTH  data input 6.
REQ-012 Port: I7  input  WIDTH  data input 7.
REQ-013 Port: Sel  input  3  select; unsigned index 0..7.
REQ-014 Port: y  output  WIDTH  registered multiplexer output.

Function
REQ-015 On each rising Clock edge with Reset_n high, y SHALL load the input indexed by Sel: 0->I0, 1->I1 ... 7->I7.
- Sel and the selected input are sampled at that same edge.
REQ-016 Latency SHALL be exactly one clock.
- A Sel or data change becomes visible on y only after the next rising edge.
- y SHALL NOT change combinationally between edges.
REQ-017 All 8 Sel codes SHALL be decoded; no code SHALL be treated as invalid.
REQ-018 Sel containing X/Z SHALL load all-zero in synthesis.
- Simulation MAY propagate X.
REQ-019 Data SHALL pass bit-exact.
- No arithmetic, no sign or width conversion.
- y[k] equals the selected input bit k for every k in 0..WIDTH-1.
REQ-020 Only the selected input SHALL affect y.
- Changes on unselected inputs SHALL leave y unchanged at the next edge.
REQ-021 A Sel change coincident with a rising edge SHALL resolve to the value settled before that edge, per standard setup timing.
REQ-022 The design SHALL contain no state other than the WIDTH-bit output register.

Reset
REQ-023 When Reset_n is low, y SHALL be forced to all zeros immediately, without waiting for a Clock edge.
REQ-024 While Reset_n stays low, y SHALL remain all zeros regardless of Clock, Sel or data.
REQ-025 On release, the first rising edge with Reset_n high SHALL load the selected input.
REQ-026 Reset asserted mid-operation SHALL discard the current y value.
- There is no recovery of the prior value.

Verification
Common setup: I0..I7 = AA, BB, CC, DD, EE, FF, 11, 22 (hex); 10 ns clock, first rising edge at 5 ns; Reset_n released before the first edge.
REQ-027 Reset check:
- Stimulus: hold Reset_n low across several clocks with Sel=5.
- Response: y = 00 throughout.
- Then release Reset_n; y = FF after the next rising edge.
REQ-028 Full select sweep:
- Stimulus: Sel stepped 0..7, one value per 10 ns cycle, each applied before its edge.
- Response: y after successive edges = AA, BB, CC, DD, EE, FF, 11, 22.
REQ-029 Latency check:
- Stimulus: change Sel from 0 to 3 mid-cycle.
- Response: y stays AA until the next rising edge, then becomes DD.
REQ-030 Isolation check:
- Stimulus: Sel=2; change I5 to 00 and I2 to 5A.
- Response: y = 5A after the next edge; the I5 change has no effect.
REQ-031 Asynchronous reset check:
- Stimulus: with y = 22, pull Reset_n low between clock edges.
- Response: y = 00 immediately, before any Clock edge.
REQ-032 Width check:
- Stimulus: instantiate WIDTH=16 with I7 = A5C3, Sel=7.
- Response: y = A5C3 after one edge.

Source files
------------

// File: rtl/mux8x1_8bit.sv
// ---------------------------------------------------------------------------
// mux8x1_8bit
//
// Registered 8-to-1 multiplexer. On every rising Clock edge, y loads the data
// input picked by Sel (0 -> I0 ... 7 -> I7). The output register is the only
// state in the block. Reset_n clears y to zero at once, without waiting for
// a clock edge.
//
// Parameters:
//   WIDTH    - data width of every input and of the output (default 8)
//
// Ports:
//   Clock    in   1      rising-edge clock for the output register
//   Reset_n  in   1      asynchronous active-low reset, clears y
//   I0..I7   in   WIDTH  data inputs
//   Sel      in   3      unsigned select index 0..7
//   y        out  WIDTH  registered multiplexer output
// ---------------------------------------------------------------------------
module mux8x1_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    input  logic [2:0]       Sel,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    // Next-state selection. All eight codes are decoded. The default arm is
    // reached only when Sel carries X/Z bits, and it loads all zeros.
    always_comb begin
        // NOTE: assigning y_d before the case means every path drives it,
        // so no latch can be inferred even if an arm is later removed.
        y_d = '0;
        case (Sel)
            3'd0:    y_d = I0;
            3'd1:    y_d = I1;
            3'd2:    y_d = I2;
            3'd3:    y_d = I3;
            3'd4:    y_d = I4;
            3'd5:    y_d = I5;
            3'd6:    y_d = I6;
            3'd7:    y_d = I7;
            default: y_d = '0;
        endcase
    end

    // Output register. Because the reset is asynchronous, y clears as soon as
    // Reset_n falls. The register holds its reset value for as long as
    // Reset_n stays low.
    always_ff @(posedge Clock or negedge Reset_n) begin
        // NOTE: non-blocking assignment keeps the register update ordered
        // after every reader of the old value in the same time step.
        if (!Reset_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_mux8x1_8bit.sv
// ---------------------------------------------------------------------------
// tb_mux8x1_8bit
//
// Runs an 8-bit instance and a 16-bit instance side by side. Both share
// Clock, Reset_n and Sel. A reference model built on arrays predicts y at
// each edge, and a compare process checks both outputs on every falling
// edge. Directed scenarios also check literal values that pin the model.
// ---------------------------------------------------------------------------
module tb_mux8x1_8bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sel;
    logic [7:0]  din [8];
    logic [15:0] win [8];
    logic [7:0]  y8;
    logic [15:0] y16;

    int checks   = 0;
    int failures = 0;

    // Reference model: the register holds the selected array element, and it
    // is cleared whenever reset is low.
    logic [7:0]  exp8  = '0;
    logic [15:0] exp16 = '0;

    // Rising edges at 5, 15, 25 ns and so on.
    always #5 clk = ~clk;

    mux8x1_8bit dut8 (
        .Clock(clk), .Reset_n(rst_n),
        .I0(din[0]), .I1(din[1]), .I2(din[2]), .I3(din[3]),
        .I4(din[4]), .I5(din[5]), .I6(din[6]), .I7(din[7]),
        .Sel(sel), .y(y8)
    );

    mux8x1_8bit #(.WIDTH(16)) dut16 (
        .Clock(clk), .Reset_n(rst_n),
        .I0(win[0]), .I1(win[1]), .I2(win[2]), .I3(win[3]),
        .I4(win[4]), .I5(win[5]), .I6(win[6]), .I7(win[7]),
        .Sel(sel), .y(y16)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp8  = '0;
            exp16 = '0;
        end else begin
            exp8  = din[sel];
            exp16 = win[sel];
        end
    end

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare against the model on every falling edge, away from the
    // active edge.
    always @(negedge clk) begin
        check("model_y8", {8'h00, y8}, {8'h00, exp8});
        check("model_y16", y16, exp16);
    end

    task automatic set_common();
        logic [7:0] init [8];
        init = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
        for (int i = 0; i < 8; i++) begin
            din[i] = init[i];
            win[i] = {8'h5A, init[i]};
        end
        win[7] = 16'hA5C3;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] sweep [8];
        sweep = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};

        set_common();
        rst_n = 1'b0;
        sel   = 3'd5;

        // Hold reset low across several edges: y must stay at zero.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_hold", {8'h00, y8}, 16'h0000);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release", {8'h00, y8}, 16'h00FF);

        // Step Sel through every code, one per cycle.
        for (int s = 0; s < 8; s++) begin
            @(negedge clk); #1;
            sel = 3'(s);
            @(posedge clk); #1;
            check("sweep", {8'h00, y8}, {8'h00, sweep[s]});
        end
        check("width16", y16, 16'hA5C3);

        // Latency: a Sel change mid-cycle shows up only after the next edge.
        @(negedge clk); #1;
        sel = 3'd0;
        @(posedge clk); #1;
        check("latency_pre", {8'h00, y8}, 16'h00AA);
        @(negedge clk); #1;
        sel = 3'd3;
        #2;
        check("latency_hold", {8'h00, y8}, 16'h00AA);
        @(posedge clk); #1;
        check("latency_post", {8'h00, y8}, 16'h00DD);

        // Isolation: a change on an unselected input has no effect on y.
        @(negedge clk); #1;
        sel    = 3'd2;
        din[5] = 8'h00;
        din[2] = 8'h5A;
        @(posedge clk); #1;
        check("isolation", {8'h00, y8}, 16'h005A);
        @(negedge clk); #1;
        din[0] = 8'hC3;
        @(posedge clk); #1;
        check("isolation_hold", {8'h00, y8}, 16'h005A);
        set_common();

        // Asynchronous reset between edges clears y at once.
        @(negedge clk); #1;
        sel = 3'd7;
        @(posedge clk); #1;
        check("pre_async", {8'h00, y8}, 16'h0022);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {8'h00, y8}, 16'h0000);
        check("async_reset16", y16, 16'h0000);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_async", {8'h00, y8}, 16'h0022);

        // Random traffic, with occasional reset pulses mid-cycle.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk); #1;
            sel = 3'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) begin
                din[i] = 8'($urandom);
                win[i] = 16'($urandom);
            end
            rst_n = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
